// File: rtl/mc_control_fsm_v2.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// writeback, waits on a memory-ready handshake with timeout, flags illegal
// opcodes and bus errors, and counts retired instructions.
module mc_control_fsm_v2 #(
  parameter int CNT_W           = 32,
  parameter int TO_W            = 8,
  parameter int MEM_TIMEOUT     = 200,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             AddrSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [4:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXEC_R   = 5'd6,
    S_ALUWB    = 5'd7,
    S_EXEC_I   = 5'd8,
    S_JAL      = 5'd9,
    S_BRANCH   = 5'd10,
    S_JALR     = 5'd11,
    S_LUI      = 5'd12,
    S_AUIPC    = 5'd13,
    S_HALT     = 5'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q;
  logic              in_wait;
  logic              timed_out;
  logic              illegal_set;
  logic              retire;

  // States that wait on the memory handshake, and the timeout condition.
  assign in_wait   = ((state_q == S_FETCH) && run) ||
                     (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timed_out = in_wait && !mem_ready && (to_cnt_q == TO_LAST);
  assign state     = state_q;

  // State register, timeout counter, sticky flags and retire counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      to_cnt_q <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      instret  <= '0;
    end else begin
      state_q <= state_d;
      if (in_wait && !mem_ready && !timed_out) to_cnt_q <= to_cnt_q + 1'b1;
      else                                     to_cnt_q <= '0;
      halted  <= halted  | (state_d == S_HALT);
      illegal <= illegal | illegal_set;
      bus_err <= bus_err | timed_out;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // Next-state and datapath control decode.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    PCUpdate    = 1'b0;
    Branch      = 1'b0;
    AddrSrc     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    illegal_set = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          MemRead   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          if (mem_ready) begin
            IRWrite  = 1'b1;
            PCUpdate = 1'b1;
            state_d  = S_DECODE;
          end else if (timed_out) begin
            state_d = S_HALT;
          end
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_BRANCH: begin
            if (funct3 != 3'b010 && funct3 != 3'b011) state_d = S_BRANCH;
            else                                      illegal_set = 1'b1;
          end
          OP_JALR: begin
            if (funct3 == 3'b000) state_d = S_JALR;
            else                  illegal_set = 1'b1;
          end
          default: illegal_set = 1'b1;
        endcase
        if (illegal_set) state_d = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AddrSrc = 1'b1;
        MemRead = 1'b1;
        if (mem_ready)      state_d = S_MEMWB;
        else if (timed_out) state_d = S_HALT;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AddrSrc  = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_HALT;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_JAL: begin
        PCUpdate = 1'b1;
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        Branch  = 1'b1;
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Immediate format select, decoded from the opcode in every state.
  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm_v2.sv
// Bench for mc_control_fsm_v2: two instances (halt-on-illegal and
// nop-on-illegal, short timeout) driven by directed and random stimulus,
// compared each cycle against an instruction-plan reference model.
module tb_mc_control_fsm_v2;

  localparam int TO = 4;
  localparam int CW_A = 32;
  localparam int CW_B = 4;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                         II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                         BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset_n, run, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;

  logic a_pc, a_br, a_as, a_mr, a_mw, a_ir, a_rw, a_halted, a_ill, a_bus;
  logic [1:0] a_rs, a_ao, a_sa, a_sb;
  logic [2:0] a_imm;
  logic [4:0] a_state;
  logic [CW_A-1:0] a_instret;
  logic b_pc, b_br, b_as, b_mr, b_mw, b_ir, b_rw, b_halted, b_ill, b_bus;
  logic [1:0] b_rs, b_ao, b_sa, b_sb;
  logic [2:0] b_imm;
  logic [4:0] b_state;
  logic [CW_B-1:0] b_instret;

  always #5 clk = ~clk;

  mc_control_fsm_v2 #(.CNT_W(CW_A), .TO_W(8), .MEM_TIMEOUT(TO), .HALT_ON_ILLEGAL(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .PCUpdate(a_pc), .Branch(a_br), .AddrSrc(a_as), .MemRead(a_mr), .MemWrite(a_mw),
    .IRWrite(a_ir), .RegWrite(a_rw), .ResultSrc(a_rs), .ALUOp(a_ao), .ALUSrcA(a_sa),
    .ALUSrcB(a_sb), .ImmSrc(a_imm), .state(a_state), .halted(a_halted), .illegal(a_ill),
    .bus_err(a_bus), .instret(a_instret));

  mc_control_fsm_v2 #(.CNT_W(CW_B), .TO_W(8), .MEM_TIMEOUT(TO), .HALT_ON_ILLEGAL(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .PCUpdate(b_pc), .Branch(b_br), .AddrSrc(b_as), .MemRead(b_mr), .MemWrite(b_mw),
    .IRWrite(b_ir), .RegWrite(b_rw), .ResultSrc(b_rs), .ALUOp(b_ao), .ALUSrcA(b_sa),
    .ALUSrcB(b_sb), .ImmSrc(b_imm), .state(b_state), .halted(b_halted), .illegal(b_ill),
    .bus_err(b_bus), .instret(b_instret));

  wire [14:0] a_outs = {a_pc, a_br, a_as, a_mr, a_mw, a_ir, a_rw, a_rs, a_ao, a_sa, a_sb};
  wire [14:0] b_outs = {b_pc, b_br, b_as, b_mr, b_mw, b_ir, b_rw, b_rs, b_ao, b_sa, b_sb};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per instance, the current step and the remaining plan
  // of steps the decoded instruction still has to walk through.
  int     m_state[2];
  int     m_cnt[2];
  int     m_plan[2][4];
  int     m_len[2];
  int     m_pos[2];
  bit     m_halted[2], m_ill[2], m_bus[2];
  longint m_instret[2];
  bit     m_hoi[2] = '{1'b1, 1'b0};
  int     m_cw[2]  = '{CW_A, CW_B};

  // Expected control vector for a step, from the control table.
  function automatic logic [14:0] exp_outs(int s, logic r, logic rdy);
    logic pc, br, ad, mr, mw, ir, rw;
    logic [1:0] rs, ao, sa, sb;
    {pc, br, ad, mr, mw, ir, rw} = '0;
    {rs, ao, sa, sb} = '0;
    case (s)
      0:  if (r) begin mr = 1; sb = 2'b10; rs = 2'b10; pc = rdy; ir = rdy; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  begin ad = 1; mr = 1; end
      4:  begin rw = 1; rs = 2'b01; end
      5:  begin ad = 1; mw = 1; end
      6:  begin sa = 2'b10; ao = 2'b10; end
      7:  rw = 1;
      8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      9:  begin pc = 1; sa = 2'b01; sb = 2'b10; end
      10: begin br = 1; sa = 2'b10; ao = 2'b01; end
      11: begin sa = 2'b10; sb = 2'b01; end
      12: begin sa = 2'b11; sb = 2'b01; end
      13: begin sa = 2'b01; sb = 2'b01; end
      default: ;
    endcase
    return {pc, br, ad, mr, mw, ir, rw, rs, ao, sa, sb};
  endfunction

  function automatic logic [2:0] exp_imm(logic [6:0] o);
    if (o == SW) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JL) return 3'b011;
    if (o == LU || o == AU) return 3'b100;
    return 3'b000;
  endfunction

  task automatic set_plan(int i, int n, int p0, int p1, int p2);
    m_len[i] = n;
    m_plan[i][0] = p0; m_plan[i][1] = p1; m_plan[i][2] = p2;
    m_pos[i] = 0;
  endtask

  task automatic model_step(int i);
    int  s;
    bit  waiting;
    bit  legal;
    s = m_state[i];
    if (!reset_n) begin
      m_state[i] = 0; m_cnt[i] = 0; m_len[i] = 0; m_pos[i] = 0;
      m_halted[i] = 0; m_ill[i] = 0; m_bus[i] = 0; m_instret[i] = 0;
      return;
    end
    waiting = (s == 0 && run) || s == 3 || s == 5;
    if (s == 14) begin
      // stays halted
    end else if (s == 0 && !run) begin
      m_cnt[i] = 0;
    end else if (waiting && !mem_ready) begin
      if (m_cnt[i] + 1 >= TO) begin
        m_state[i] = 14; m_bus[i] = 1; m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
      end
    end else begin
      m_cnt[i] = 0;
      if (s == 0) begin
        m_state[i] = 1;
      end else if (s == 1) begin
        legal = 1;
        case (op)
          LW: set_plan(i, 3, 2, 3, 4);
          SW: set_plan(i, 2, 2, 5, 0);
          RR: set_plan(i, 2, 6, 7, 0);
          II: set_plan(i, 2, 8, 7, 0);
          JL: set_plan(i, 2, 9, 7, 0);
          LU: set_plan(i, 2, 12, 7, 0);
          AU: set_plan(i, 2, 13, 7, 0);
          BR: if (funct3 != 3'd2 && funct3 != 3'd3) set_plan(i, 1, 10, 0, 0); else legal = 0;
          JR: if (funct3 == 3'd0) set_plan(i, 3, 11, 9, 7); else legal = 0;
          default: legal = 0;
        endcase
        if (!legal) begin
          m_ill[i] = 1;
          m_state[i] = m_hoi[i] ? 14 : 0;
        end else begin
          m_state[i] = m_plan[i][0];
          m_pos[i] = 1;
        end
      end else if (m_pos[i] < m_len[i]) begin
        m_state[i] = m_plan[i][m_pos[i]];
        m_pos[i]++;
      end else begin
        m_instret[i] = (m_instret[i] + 1) % (64'd1 << m_cw[i]);
        m_state[i] = 0;
      end
    end
    if (m_state[i] == 14) m_halted[i] = 1;
  endtask

  task automatic compare_all();
    check("a.state",   32'(a_state),   32'(m_state[0]));
    check("a.ctrl",    32'(a_outs),    32'(exp_outs(m_state[0], run, mem_ready)));
    check("a.imm",     32'(a_imm),     32'(exp_imm(op)));
    check("a.halted",  32'(a_halted),  32'(m_halted[0]));
    check("a.illegal", 32'(a_ill),     32'(m_ill[0]));
    check("a.bus_err", 32'(a_bus),     32'(m_bus[0]));
    check("a.instret", 32'(a_instret), 32'(m_instret[0]));
    check("b.state",   32'(b_state),   32'(m_state[1]));
    check("b.ctrl",    32'(b_outs),    32'(exp_outs(m_state[1], run, mem_ready)));
    check("b.imm",     32'(b_imm),     32'(exp_imm(op)));
    check("b.halted",  32'(b_halted),  32'(m_halted[1]));
    check("b.illegal", 32'(b_ill),     32'(m_ill[1]));
    check("b.bus_err", 32'(b_bus),     32'(m_bus[1]));
    check("b.instret", 32'(b_instret), 32'(m_instret[1]));
  endtask

  // One clock: drive at the falling edge, compare, then advance the model
  // to match the rising edge that follows.
  task automatic cyc(input logic rn, input logic r, input logic rdy,
                     input logic [6:0] o, input logic [2:0] f, input bit cmp = 1'b1);
    @(negedge clk);
    reset_n = rn; run = r; mem_ready = rdy; op = o; funct3 = f;
    #1;
    if (cmp) compare_all();
    model_step(0);
    model_step(1);
  endtask

  task automatic go(input logic [6:0] o, input logic [2:0] f, input int n);
    for (int k = 0; k < n; k++) cyc(1, 1, 1, o, f);
  endtask

  task automatic idle();
    cyc(1, 0, 1, RR, 3'd0);
  endtask

  logic [6:0] ops[9] = '{LW, SW, RR, II, BR, JL, JR, LU, AU};

  initial begin
    reset_n = 0; run = 1; mem_ready = 1; op = RR; funct3 = 0;
    cyc(0, 1, 1, RR, 3'd0, 1'b0);
    cyc(0, 1, 1, RR, 3'd0);
    check("reset.state", 32'(a_state), 32'd0);

    // R-type: 0,1,6,7 then back to FETCH with one retirement.
    go(RR, 3'd0, 4);
    idle();
    check("r.state", 32'(a_state), 32'd0);
    check("r.instret", a_instret, 32'd1);

    // LW with three not-ready cycles in MEMREAD.
    go(LW, 3'd2, 3);
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, LW, 3'd2);
    go(LW, 3'd2, 2);
    idle();
    check("lw.instret", a_instret, 32'd2);
    check("lw.bus_err", 32'(a_bus), 32'd0);

    // JALR, LUI, AUIPC.
    go(JR, 3'd0, 5);
    idle();
    check("jalr.instret", a_instret, 32'd3);
    go(LU, 3'd0, 4);
    check("lui.imm", 32'(a_imm), 32'd4);
    idle();
    go(AU, 3'd5, 4);
    idle();
    check("auipc.instret", a_instret, 32'd5);

    // run low in FETCH holds with no enables.
    for (int k = 0; k < 5; k++) idle();
    check("run0.memread", 32'(a_mr), 32'd0);

    // SW with memory stuck not-ready times out into HALT.
    go(SW, 3'd2, 3);
    for (int k = 0; k < TO; k++) cyc(1, 1, 0, SW, 3'd2);
    cyc(1, 1, 0, SW, 3'd2);
    check("sw.state", 32'(a_state), 32'd14);
    check("sw.bus_err", 32'(a_bus), 32'd1);
    check("sw.memwrite", 32'(a_mw), 32'd0);

    // Illegal opcode: halt on one instance, NOP on the other.
    cyc(0, 1, 1, RR, 3'd0);
    go(BAD, 3'd0, 2);
    idle();
    check("ill.a_state", 32'(a_state), 32'd14);
    check("ill.b_state", 32'(b_state), 32'd0);
    check("ill.b_flag", 32'(b_ill), 32'd1);
    check("ill.b_instret", 32'(b_instret), 32'd0);

    // Reset mid-MEMREAD, then a fresh load must not inherit the wait count.
    cyc(0, 1, 1, RR, 3'd0);
    go(LW, 3'd2, 3);
    cyc(1, 1, 0, LW, 3'd2);
    cyc(1, 1, 0, LW, 3'd2);
    cyc(0, 1, 0, LW, 3'd2);
    idle();
    check("rst.state", 32'(a_state), 32'd0);
    check("rst.instret", a_instret, 32'd0);
    go(LW, 3'd2, 3);
    for (int k = 0; k < TO - 1; k++) cyc(1, 1, 0, LW, 3'd2);
    go(LW, 3'd2, 2);
    idle();
    check("rst.bus_err", 32'(a_bus), 32'd0);
    check("rst.lw_instret", a_instret, 32'd1);

    // Random episodes.
    for (int ep = 0; ep < 40; ep++) begin
      int pct;
      logic [6:0] o;
      logic [2:0] f;
      pct = int'($urandom_range(50, 95));
      o = RR; f = 0;
      cyc(0, 1, 1, o, f);
      for (int c = 0; c < 200; c++) begin
        logic rn, r, rdy;
        rn  = ($urandom % 200) != 0;
        r   = ($urandom % 10) != 0;
        rdy = int'($urandom % 100) < pct;
        if ((m_state[0] == 0 || m_state[0] == 14) && (m_state[1] == 0 || m_state[1] == 14)) begin
          if (($urandom % 5) != 0) o = ops[$urandom % 9];
          else                     o = 7'($urandom);
          f = 3'($urandom);
        end
        cyc(rn, r, rdy, o, f);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
